lppm_tx: RTL and testbench
==========================

LPPM_TX -- requirements
Module: lppm_tx

Interface
REQ-001 Parameter SYM_BITS, default 2: bits per symbol; a frame has 2^SYM_BITS data slots; legal range 1..8.
REQ-002 Parameter SLOT_CYCLES, default 4: clocks per slot; legal range >=1.
REQ-003 Parameter PULSE_CYCLES, default 2: ppm high time in the chosen slot; legal range 1..SLOT_CYCLES.
REQ-004 Parameter GUARD_SLOTS, default 1: all-low slots appended to each frame; legal range >=0.
REQ-005 Parameter GRAY_MAP, default 0: 1 selects Gray-coded slot mapping, 0 selects binary mapping.
REQ-006 clk  input  1  single clock; all logic is rising-edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sym_data  input  SYM_BITS  symbol to transmit.
REQ-009 sym_valid  input  1  sym_data is valid.
REQ-010 sym_ready  output  1  block accepts a symbol this cycle; transfer on sym_valid&&sym_ready at a rising edge.
REQ-011 abort  input  1  synchronous: stop the current frame and flush the buffer.
REQ-012 ppm  output  1  registered PPM waveform.
REQ-013 frame_start  output  1  registered, high for frame cycle 0 of every frame.
REQ-014 ppm_done  output  1  registered, high for the last cycle of every completed frame.
REQ-015 busy  output  1  high while a frame is in progress or the buffer is non-empty.

Function
REQ-016 Frame length F = (2^SYM_BITS + GUARD_SLOTS) * SLOT_CYCLES cycles; frame cycles are numbered 0..F-1.
REQ-017 Slot index s = sym when GRAY_MAP=0, and s = sym ^ (sym>>1) when GRAY_MAP=1.
REQ-018 ppm is high exactly in frame cycles s*SLOT_CYCLES .. s*SLOT_CYCLES+PULSE_CYCLES-1 and low in all other cycles, including guard slots and idle.
REQ-019 Input buffer is a 2-entry FIFO; sym_ready = !full, forced to 0 while rst_n is low; a push and a pop in the same cycle are both honoured.
REQ-020 Engine states are IDLE, DATA, GUARD; counters are cyc_cnt (0..SLOT_CYCLES-1) and slot_cnt (0..2^SYM_BITS+GUARD_SLOTS-1).
REQ-021 IDLE->DATA at the first edge where the FIFO is non-empty: the head entry is popped and latched, and frame cycle 0 is driven from that edge, giving 1-clock latency from the accept edge.
REQ-022 DATA->GUARD after the last cycle of slot 2^SYM_BITS-1 when GUARD_SLOTS>0; the GUARD state is skipped entirely when GUARD_SLOTS=0.
REQ-023 At frame cycle F-1, if the FIFO is non-empty the next frame starts on the following cycle with no gap, and the state goes back to DATA; otherwise the state goes to IDLE.
REQ-024 ppm_done is never asserted for an aborted or reset-truncated frame.
REQ-025 abort=1 at an edge: state->IDLE, FIFO emptied, ppm/frame_start/ppm_done driven to 0 from that edge; any push in the same cycle is discarded; abort has priority over every other event.
REQ-026 All counters wrap only through the transitions defined above; no other wrap behaviour exists.

Reset
REQ-027 Asserting rst_n low immediately sets ppm=0, frame_start=0, ppm_done=0, busy=0, state=IDLE, counters=0, and FIFO empty.
REQ-028 Reset mid-frame truncates the frame without a ppm_done pulse; after release the block is idle and sym_ready=1.

Verification (defaults: F=20)
REQ-029 Reset: hold rst_n low 4 cycles with sym_valid=1 -> sym_ready=0, all outputs 0; after release sym_ready=1, busy=0.
REQ-030 Single symbol: accept 2'b10 at edge k -> frame_start at k+1; ppm high for frame cycles 8-9 only; ppm_done at frame cycle 19; busy=0 afterwards.
REQ-031 Back-to-back: hold sym_valid with symbols 0,3,1,2 -> sym_ready low while 2 entries are buffered; 80 contiguous cycles; ppm pulses at frame cycles 0, 12, 4, 8 of successive frames; 4 ppm_done pulses 20 cycles apart.
REQ-032 GRAY_MAP=1: symbol 2'b10 -> ppm high for frame cycles 12-13 (slot 3).
REQ-033 Abort: issue abort at frame cycle 5 with one symbol queued -> ppm=0 from the next cycle, no ppm_done, FIFO empty, busy=0.
REQ-034 Async reset at frame cycle 9 -> ppm falls without waiting for a clock edge; no ppm_done; the next accepted symbol starts a fresh frame 1 clock after it is accepted.

Source files
------------

// File: rtl/lppm_tx.sv
// lppm_tx: pulse-position modulation transmitter with a 2-entry symbol buffer and guard slots
module lppm_tx #(
    parameter int SYM_BITS     = 2,
    parameter int SLOT_CYCLES  = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_SLOTS  = 1,
    parameter int GRAY_MAP     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SYM_BITS-1:0] sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic                abort,
    output logic                ppm,
    output logic                frame_start,
    output logic                ppm_done,
    output logic                busy
);
    localparam int NDATA = 1 << SYM_BITS;
    localparam int NSLOT = NDATA + GUARD_SLOTS;
    localparam int SW    = $clog2(NSLOT);
    localparam int CW    = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_DATA = SW'(NDATA - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOT - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, GUARD} state_t;

    state_t              state, nxt_state;
    logic [CW-1:0]       cyc_cnt, nxt_cyc;
    logic [SW-1:0]       slot_cnt, nxt_slot;
    logic [SYM_BITS-1:0] cur_slot, nxt_sym, head, head_slot;
    logic [SYM_BITS-1:0] mem [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          count;
    logic                empty, push, pop, last_cyc, last_frame, start;
    logic                nxt_ppm, nxt_fs, nxt_done;

    // FIFO flags, symbol mapping and engine next-state / next-output decode
    always_comb begin
        empty      = count == 2'd0;
        sym_ready  = rst_n && count != 2'd2;
        push       = sym_valid && sym_ready && !abort;
        head       = mem[rd_ptr];
        head_slot  = GRAY_MAP != 0 ? head ^ (head >> 1) : head;
        last_cyc   = cyc_cnt == LAST_CYC;
        last_frame = state != IDLE && last_cyc && slot_cnt == LAST_SLOT;
        start      = !empty && (state == IDLE || last_frame);
        busy       = state != IDLE || !empty;
        nxt_state  = state;
        nxt_cyc    = cyc_cnt;
        nxt_slot   = slot_cnt;
        nxt_sym    = cur_slot;
        pop        = 1'b0;
        if (abort) begin
            nxt_state = IDLE;
            nxt_cyc   = '0;
            nxt_slot  = '0;
        end else if (start) begin
            pop       = 1'b1;
            nxt_state = DATA;
            nxt_cyc   = '0;
            nxt_slot  = '0;
            nxt_sym   = head_slot;
        end else if (last_frame) begin
            nxt_state = IDLE;
            nxt_cyc   = '0;
            nxt_slot  = '0;
        end else if (state != IDLE) begin
            nxt_cyc   = last_cyc ? '0 : cyc_cnt + CW'(1);
            nxt_slot  = last_cyc ? slot_cnt + SW'(1) : slot_cnt;
            nxt_state = last_cyc && slot_cnt == LAST_DATA ? GUARD : state;
        end
        nxt_ppm  = nxt_state == DATA && nxt_slot == SW'(nxt_sym) && 32'(nxt_cyc) < PULSE_CYCLES;
        nxt_fs   = nxt_state != IDLE && nxt_slot == '0 && nxt_cyc == '0;
        nxt_done = nxt_state != IDLE && nxt_slot == LAST_SLOT && nxt_cyc == LAST_CYC;
    end

    // Engine registers; outputs are registered copies of the decode for the cycle being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            slot_cnt    <= '0;
            cur_slot    <= '0;
            ppm         <= 1'b0;
            frame_start <= 1'b0;
            ppm_done    <= 1'b0;
        end else begin
            state       <= nxt_state;
            cyc_cnt     <= nxt_cyc;
            slot_cnt    <= nxt_slot;
            cur_slot    <= nxt_sym;
            ppm         <= nxt_ppm;
            frame_start <= nxt_fs;
            ppm_done    <= nxt_done;
        end
    end

    // Two-entry symbol buffer; abort flushes it and drops any same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sym_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_lppm_tx.sv
// tb_lppm_tx: directed checks of the PPM transmitter, binary and Gray-mapped instances side by side
module tb_lppm_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sym_data = 2'd0;
    logic       sym_valid = 1'b0;
    logic       abort = 1'b0;
    logic       sym_ready, ppm, frame_start, ppm_done, busy;
    logic       g_ready, g_ppm, g_fs, g_done, g_busy;
    int         errors = 0;
    int         checks = 0;
    int         idx;
    logic       acc;
    logic [1:0] syms [4];
    logic [1:0] gsyms [4];

    lppm_tx dut (
        .clk(clk), .rst_n(rst_n), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .abort(abort), .ppm(ppm), .frame_start(frame_start),
        .ppm_done(ppm_done), .busy(busy)
    );

    lppm_tx #(.GRAY_MAP(1)) dut_gray (
        .clk(clk), .rst_n(rst_n), .sym_data(sym_data), .sym_valid(sym_valid),
        .sym_ready(g_ready), .abort(abort), .ppm(g_ppm), .frame_start(g_fs),
        .ppm_done(g_done), .busy(g_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        syms[0] = 2'd0; syms[1] = 2'd3; syms[2] = 2'd1; syms[3] = 2'd2;
        gsyms[0] = 2'd0; gsyms[1] = 2'd2; gsyms[2] = 2'd1; gsyms[3] = 2'd3;

        // reset held with sym_valid high
        sym_valid = 1'b1;
        sym_data  = 2'd2;
        repeat (4) step();
        chk("rst_ready", sym_ready, 1'b0);
        chk("rst_ppm", ppm, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_done", ppm_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gppm", g_ppm, 1'b0);
        sym_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("rel_ready", sym_ready, 1'b1);
        chk("rel_busy", busy, 1'b0);

        // single symbol 2'b10: binary slot 2 (cycles 8-9), Gray slot 3 (cycles 12-13)
        sym_valid = 1'b1;
        sym_data  = 2'b10;
        step();
        sym_valid = 1'b0;
        chk("acc_busy", busy, 1'b1);
        chk("acc_fs", frame_start, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("one_ppm_c%0d", c), ppm, c == 8 || c == 9);
            chk($sformatf("one_fs_c%0d", c), frame_start, c == 0);
            chk($sformatf("one_done_c%0d", c), ppm_done, c == 19);
            chk($sformatf("gray_ppm_c%0d", c), g_ppm, c == 12 || c == 13);
        end
        step();
        chk("one_busy_after", busy, 1'b0);
        chk("one_done_after", ppm_done, 1'b0);

        // back-to-back 0,3,1,2 with sym_valid held
        idx       = 0;
        sym_valid = 1'b1;
        sym_data  = syms[0];
        step();
        idx      = 1;
        sym_data = syms[1];
        for (int t = 0; t < 80; t++) begin
            acc = sym_valid && sym_ready;
            step();
            if (acc) begin
                idx++;
                if (idx == 4) sym_valid = 1'b0;
                else sym_data = syms[idx];
            end
            if (t == 5) chk("b2b_ready_full", sym_ready, 1'b0);
            chk($sformatf("b2b_ppm_t%0d", t), ppm,
                (t % 20) / 4 == int'(syms[t / 20]) && (t % 4) < 2);
            chk($sformatf("b2b_gppm_t%0d", t), g_ppm,
                (t % 20) / 4 == int'(gsyms[t / 20]) && (t % 4) < 2);
            chk($sformatf("b2b_fs_t%0d", t), frame_start, t % 20 == 0);
            chk($sformatf("b2b_done_t%0d", t), ppm_done, t % 20 == 19);
        end
        step();
        chk("b2b_busy_after", busy, 1'b0);

        // abort at frame cycle 5 with one symbol queued
        sym_valid = 1'b1;
        sym_data  = 2'd1;
        step();
        sym_data = 2'd2;
        step();
        sym_valid = 1'b0;
        repeat (5) step();
        chk("abt_ppm_before", ppm, 1'b1);
        chk("abt_busy_before", busy, 1'b1);
        abort     = 1'b1;
        sym_valid = 1'b1;
        sym_data  = 2'd3;
        step();
        abort     = 1'b0;
        sym_valid = 1'b0;
        chk("abt_ppm", ppm, 1'b0);
        chk("abt_busy", busy, 1'b0);
        chk("abt_ready", sym_ready, 1'b1);
        for (int c = 0; c < 25; c++) begin
            step();
            chk($sformatf("abt_done_%0d", c), ppm_done, 1'b0);
            chk($sformatf("abt_idle_ppm_%0d", c), ppm, 1'b0);
            chk($sformatf("abt_idle_fs_%0d", c), frame_start, 1'b0);
        end

        // asynchronous reset at frame cycle 9
        sym_valid = 1'b1;
        sym_data  = 2'b10;
        step();
        sym_valid = 1'b0;
        repeat (10) step();
        chk("ar_ppm_before", ppm, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ppm", ppm, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ready", sym_ready, 1'b0);
        repeat (3) begin
            step();
            chk("ar_done", ppm_done, 1'b0);
        end
        rst_n     = 1'b1;
        sym_valid = 1'b1;
        sym_data  = 2'd0;
        #1;
        chk("ar_rel_ready", sym_ready, 1'b1);
        step();
        sym_valid = 1'b0;
        chk("ar_acc_fs", frame_start, 1'b0);
        chk("ar_acc_busy", busy, 1'b1);
        step();
        chk("ar_new_fs", frame_start, 1'b1);
        chk("ar_new_ppm", ppm, 1'b1);
        chk("ar_new_gppm", g_ppm, 1'b1);
        chk("ar_new_done", ppm_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
